// File: rtl/mmu_seq.sv
// Command sequencer for the systolic MMU: loads a weight tile, commits it,
// streams activation rows, drains the array and flags result rows and completion.
module mmu_seq #(
  parameter int ARRAY_DIM = 8,
  parameter int ROWS_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ROWS_W-1:0] cmd_rows,
  input  logic              wf_valid,
  output logic              wf_rd,
  input  logic              af_valid,
  output logic              af_rd,
  output logic              af_zero,
  output logic              global_w_wen,
  output logic              w_wen,
  output logic              w_invalid,
  output logic              en,
  output logic              res_valid,
  output logic              busy,
  output logic              done
);

  localparam int WCNT_W    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int DRAIN_LEN = 2 * ARRAY_DIM;
  localparam int DCNT_W    = $clog2(DRAIN_LEN);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ARRAY_DIM - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_LEN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [WCNT_W-1:0]    wcnt;
  logic [ROWS_W-1:0]    rows;
  logic [ROWS_W-1:0]    rcnt;
  logic [DCNT_W-1:0]    dcnt;
  logic [DRAIN_LEN-1:0] res_pipe;

  logic st_idle;
  logic st_load;
  logic st_commit;
  logic st_stream;
  logic st_drain;
  logic st_done;
  logic w_xfer;
  logic a_xfer;
  logic last_row;

  assign st_idle   = (state == S_IDLE);
  assign st_load   = (state == S_LOAD);
  assign st_commit = (state == S_COMMIT);
  assign st_stream = (state == S_STREAM);
  assign st_drain  = (state == S_DRAIN);
  assign st_done   = (state == S_DONE);

  // Feeder handshakes are only honoured in their own phase.
  assign w_xfer   = st_load & wf_valid;
  assign a_xfer   = st_stream & af_valid;
  assign last_row = (rcnt == (rows - ROWS_W'(1)));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_LOAD;
      S_LOAD:   if (w_xfer && (wcnt == WCNT_LAST)) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = (rows == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (a_xfer && last_row) state_nxt = S_DRAIN;
      S_DRAIN:  if (dcnt == DCNT_LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rows     <= '0;
      rcnt     <= '0;
      dcnt     <= '0;
      res_pipe <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rows <= cmd_rows;
            wcnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) wcnt <= wcnt + WCNT_W'(1);
        end
        S_COMMIT: begin
          rcnt <= '0;
        end
        S_STREAM: begin
          if (a_xfer) rcnt <= rcnt + ROWS_W'(1);
          if (a_xfer && last_row) dcnt <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + DCNT_W'(1);
        end
        default: ;
      endcase
      // Result tracker only moves when the array itself advances.
      if (en) res_pipe <= {res_pipe[DRAIN_LEN-2:0], a_xfer};
    end
  end

  assign cmd_ready    = st_idle;
  assign busy         = ~st_idle;
  assign global_w_wen = st_load;
  assign wf_rd        = w_xfer;
  assign w_wen        = w_xfer;
  assign w_invalid    = st_commit;
  assign en           = a_xfer | st_drain;
  assign af_rd        = a_xfer;
  assign af_zero      = st_drain;
  assign done         = st_done;
  assign res_valid    = res_pipe[DRAIN_LEN-1] & en;

endmodule

// File: tb/tb_mmu_seq.sv
// Bench for mmu_seq: work-remaining reference model checked every cycle, plus
// hand-computed per-command pulse counts and latencies.
module tb_mmu_seq;

  localparam int AD   = 4;
  localparam int RW   = 16;
  localparam int NCMD = 7;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_COMMIT = 2;
  localparam int P_STREAM = 3;
  localparam int P_DRAIN  = 4;
  localparam int P_DONE   = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [RW-1:0] cmd_rows = '0;
  logic          wf_valid = 1'b0;
  logic          af_valid = 1'b0;
  logic          cmd_ready, wf_rd, af_rd, af_zero, global_w_wen, w_wen;
  logic          w_invalid, en, res_valid, busy, done;

  always #5 clk = ~clk;

  mmu_seq #(.ARRAY_DIM(AD), .ROWS_W(RW)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows), .wf_valid(wf_valid), .wf_rd(wf_rd),
    .af_valid(af_valid), .af_rd(af_rd), .af_zero(af_zero),
    .global_w_wen(global_w_wen), .w_wen(w_wen), .w_invalid(w_invalid),
    .en(en), .res_valid(res_valid), .busy(busy), .done(done)
  );

  // Hand-computed per-command expectations (AD=4, drain 8 cycles).
  int exp_gww [NCMD] = '{4, 6, 4, 4, 4, 4, 4};
  int exp_wrd [NCMD] = '{4, 4, 4, 4, 4, 4, 4};
  int exp_winv[NCMD] = '{1, 1, 1, 1, 1, 1, 1};
  int exp_en  [NCMD] = '{11, 10, 11, 0, 10, 9, 9};
  int exp_afrd[NCMD] = '{3, 2, 3, 0, 2, 1, 1};
  int exp_res [NCMD] = '{3, 2, 3, 0, 2, 1, 1};
  int exp_lat [NCMD] = '{17, 18, 19, 6, 16, 15, 15};
  int exp_gap [NCMD] = '{-1, -1, -1, -1, -1, -1, 1};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_phase = P_IDLE;
  int m_rows = 0, m_wleft = 0, m_rleft = 0, m_dleft = 0;
  int m_pend[$];

  int a_gww = 0, a_wrd = 0, a_wwen = 0, a_winv = 0, a_en = 0, a_afrd = 0, a_res = 0;
  int a_gap = 0, fire_cyc = 0, last_done = 0, k = 0;
  bit rst_seen = 1'b0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  logic e_ready, e_busy, e_gww, e_wrd, e_winv, e_en, e_afrd, e_afz, e_done, e_res;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cmd %0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    e_ready = (m_phase == P_IDLE);
    e_busy  = (m_phase != P_IDLE);
    e_gww   = (m_phase == P_LOAD);
    e_wrd   = (m_phase == P_LOAD) && wf_valid;
    e_winv  = (m_phase == P_COMMIT);
    e_afrd  = (m_phase == P_STREAM) && af_valid;
    e_en    = e_afrd || (m_phase == P_DRAIN);
    e_afz   = (m_phase == P_DRAIN);
    e_done  = (m_phase == P_DONE);
    e_res   = 1'b0;
    // Each streamed row emerges on the 2*AD-th array advance after it entered.
    if (e_en) begin
      foreach (m_pend[i]) m_pend[i]--;
      if (m_pend.size() > 0 && m_pend[0] == 0) begin
        e_res = 1'b1;
        void'(m_pend.pop_front());
      end
    end
    if (e_afrd) m_pend.push_back(2 * AD);

    chk("cmd_ready", cmd_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("global_w_wen", global_w_wen, e_gww);
    chk("wf_rd", wf_rd, e_wrd);
    chk("w_wen", w_wen, e_wrd);
    chk("w_invalid", w_invalid, e_winv);
    chk("en", en, e_en);
    chk("af_rd", af_rd, e_afrd);
    chk("af_zero", af_zero, e_afz);
    chk("done", done, e_done);
    chk("res_valid", res_valid, e_res);
    chk("w_wen_en_excl", w_wen & en, 1'b0);

    if (rst_seen && rstn) begin
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_en", en, 1'b0);
      chk("rst_gww", global_w_wen, 1'b0);
    end
    rst_seen = !rstn;

    a_gww  += int'(global_w_wen);
    a_wrd  += int'(wf_rd);
    a_wwen += int'(w_wen);
    a_winv += int'(w_invalid);
    a_en   += int'(en);
    a_afrd += int'(af_rd);
    a_res  += int'(res_valid);

    if (done === 1'b1) begin
      if (k >= NCMD) begin
        chki("done_count", k + 1, NCMD);
      end else begin
        chki("gww_cycles", a_gww, exp_gww[k]);
        chki("wf_rd_pulses", a_wrd, exp_wrd[k]);
        chki("w_wen_pulses", a_wwen, exp_wrd[k]);
        chki("w_invalid_cycles", a_winv, exp_winv[k]);
        chki("en_cycles", a_en, exp_en[k]);
        chki("af_rd_pulses", a_afrd, exp_afrd[k]);
        chki("res_valid_pulses", a_res, exp_res[k]);
        chki("done_latency", cyc - fire_cyc, exp_lat[k]);
        if (exp_gap[k] >= 0) chki("done_to_fire_gap", a_gap, exp_gap[k]);
      end
      k++;
      last_done = cyc;
    end

    if (end_req && !end_done) begin
      chki("commands_completed", k, NCMD);
      end_done = 1'b1;
    end

    if (!rstn) begin
      m_phase = P_IDLE;
      m_pend.delete();
      a_gww = 0; a_wrd = 0; a_wwen = 0; a_winv = 0; a_en = 0; a_afrd = 0; a_res = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (cmd_valid) begin
          m_rows  = int'(cmd_rows);
          m_wleft = AD;
          m_phase = P_LOAD;
          a_gww = 0; a_wrd = 0; a_wwen = 0; a_winv = 0; a_en = 0; a_afrd = 0; a_res = 0;
          a_gap    = cyc - last_done;
          fire_cyc = cyc;
        end
        P_LOAD: if (wf_valid) begin
          m_wleft--;
          if (m_wleft == 0) m_phase = P_COMMIT;
        end
        P_COMMIT: begin
          if (m_rows == 0) m_phase = P_DONE;
          else begin
            m_rleft = m_rows;
            m_phase = P_STREAM;
          end
        end
        P_STREAM: if (af_valid) begin
          m_rleft--;
          if (m_rleft == 0) begin
            m_dleft = 2 * AD;
            m_phase = P_DRAIN;
          end
        end
        P_DRAIN: begin
          m_dleft--;
          if (m_dleft == 0) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  logic [31:0] wf_pat = '1;
  logic [31:0] af_pat = '1;
  int wi = 0;
  int ai = 0;
  int nd = 0;

  // Feeder valids follow their pattern only inside their own phase, else held high.
  task automatic step();
    @(posedge clk);
    #1;
    if (m_phase == P_LOAD) begin
      wf_valid = wf_pat[wi];
      if (wi < 31) wi++;
    end else begin
      wf_valid = 1'b1;
      wi = 0;
    end
    if (m_phase == P_STREAM) begin
      af_valid = af_pat[ai];
      if (ai < 31) ai++;
    end else begin
      af_valid = 1'b1;
      ai = 0;
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (m_phase == P_IDLE) return;
      step();
    end
    $display("FAIL wait_idle: phase %0d after %0d cycles, required %0d", m_phase, bound, P_IDLE);
    $fatal(1, "sequencer did not return to idle");
  endtask

  task automatic run_cmd(input int rows, input logic [31:0] wp, input logic [31:0] ap);
    wf_pat    = wp;
    af_pat    = ap;
    cmd_rows  = RW'(rows);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_idle(300);
    step();
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();

    run_cmd(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_cmd(2, 32'hFFFF_FFF3, 32'hFFFF_FFFF);
    run_cmd(3, 32'hFFFF_FFFF, 32'hFFFF_FFF5);
    run_cmd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    wf_pat    = '1;
    af_pat    = '1;
    cmd_rows  = RW'(5);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && m_phase != P_STREAM; i++) step();
    if (m_phase != P_STREAM) begin
      $display("FAIL reach_stream: phase %0d, required %0d", m_phase, P_STREAM);
      $fatal(1, "stream phase not reached");
    end
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    run_cmd(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    cmd_rows  = RW'(1);
    cmd_valid = 1'b1;
    nd = 0;
    for (int i = 0; i < 200 && nd < 2; i++) begin
      step();
      if (m_phase == P_DONE) begin
        nd++;
        if (nd == 2) cmd_valid = 1'b0;
      end
    end
    if (nd < 2) begin
      $display("FAIL back_to_back: %0d completions, required 2", nd);
      $fatal(1, "back-to-back commands stalled");
    end
    wait_idle(100);
    repeat (3) step();

    end_req = 1'b1;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
